// File: rtl/laserdrop_pkg.sv
// Shared LaserDrop definitions: FTDI bridge FSM states and timing defaults.
package laserdrop_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_STROBE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    RECOVER
  } ftdi_state_t;

  localparam int FTDI_RD_PULSE_DEF = 3;
  localparam int FTDI_WR_PULSE_DEF = 3;
  localparam int FTDI_GAP_DEF      = 3;
  localparam int STALL_LIMIT       = 256;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit double-flop synchronizer; resets to 1 so active-low flags read inactive.
module sync_2ff (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ftdi_fifo_bridge.sv
// FT245-style async FIFO bridge between FTDI pins and LaserDrop byte streams.
// Optional FTDI_STATS_EN adds rx/tx byte counters and a sticky stall flag.
module ftdi_fifo_bridge
  import laserdrop_pkg::*;
#(
  parameter int RD_PULSE = FTDI_RD_PULSE_DEF,
  parameter int WR_PULSE = FTDI_WR_PULSE_DEF,
  parameter int GAP      = FTDI_GAP_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en,
  input  logic       rxf,
  input  logic       txe,
  input  logic [7:0] adbus_in,
  output logic [7:0] adbus_out,
  output logic       adbus_tri,
  output logic       ftdi_rd,
  output logic       ftdi_wr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
`ifdef FTDI_STATS_EN
  ,
  output logic [15:0] rx_count,
  output logic [15:0] tx_count,
  output logic        stall_seen
`endif
);

  localparam logic [3:0] RD_LAST  = 4'(RD_PULSE - 1);
  localparam logic [3:0] WR_LAST  = 4'(WR_PULSE - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  logic        rxf_s, txe_s;
  ftdi_state_t state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        prio, prio_d;  // 0 = read side wins the next tie
  logic        rd_ok, wr_ok, grant_rd, grant_wr;
  logic        ftdi_rd_d, ftdi_wr_d, adbus_tri_d, capture_rx;

  sync_2ff u_sync_rxf (.clock(clock), .reset_n(reset_n), .d(rxf), .q(rxf_s));
  sync_2ff u_sync_txe (.clock(clock), .reset_n(reset_n), .d(txe), .q(txe_s));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      prio  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      prio  <= prio_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt + 4'd1;
    prio_d      = prio;
    ftdi_rd_d   = 1'b1;
    ftdi_wr_d   = 1'b1;
    adbus_tri_d = 1'b0;
    capture_rx  = 1'b0;
    tx_ready    = 1'b0;
    rd_ok       = en & ~rxf_s & ~rx_valid;
    wr_ok       = en & ~txe_s & tx_valid;
    grant_rd    = rd_ok & (~wr_ok | ~prio);
    grant_wr    = wr_ok & (~rd_ok | prio);
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (rd_ok && wr_ok) prio_d = ~prio;
        if (grant_rd) begin
          state_d   = RD_STROBE;
          ftdi_rd_d = 1'b0;
        end else if (grant_wr) begin
          state_d     = WR_SETUP;
          adbus_tri_d = 1'b1;
          tx_ready    = 1'b1;
        end
      end
      RD_STROBE: begin
        // The bus byte is sampled on the edge that ends the last low cycle.
        if (cnt == RD_LAST) begin
          capture_rx = 1'b1;
          state_d    = RECOVER;
          cnt_d      = '0;
        end else begin
          ftdi_rd_d = 1'b0;
        end
      end
      WR_SETUP: begin
        adbus_tri_d = 1'b1;
        ftdi_wr_d   = 1'b0;
        state_d     = WR_STROBE;
        cnt_d       = '0;
      end
      WR_STROBE: begin
        adbus_tri_d = 1'b1;
        if (cnt == WR_LAST) state_d = WR_HOLD;
        else                ftdi_wr_d = 1'b0;
      end
      WR_HOLD: begin
        state_d = RECOVER;
        cnt_d   = '0;
      end
      RECOVER: begin
        if (cnt == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ftdi_rd   <= 1'b1;
      ftdi_wr   <= 1'b1;
      adbus_tri <= 1'b0;
      adbus_out <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      ftdi_rd   <= ftdi_rd_d;
      ftdi_wr   <= ftdi_wr_d;
      adbus_tri <= adbus_tri_d;
      if (tx_valid && tx_ready) adbus_out <= tx_data;
      if (capture_rx) begin
        rx_data  <= adbus_in;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef FTDI_STATS_EN
  logic [8:0] hold_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_count   <= '0;
      tx_count   <= '0;
      hold_cnt   <= '0;
      stall_seen <= 1'b0;
    end else begin
      if (capture_rx) rx_count <= rx_count + 16'd1;
      if (tx_valid && tx_ready) tx_count <= tx_count + 16'd1;
      if (!rx_valid)                      hold_cnt <= '0;
      else if (hold_cnt != 9'(STALL_LIMIT)) hold_cnt <= hold_cnt + 9'd1;
      if (rx_valid && hold_cnt >= 9'(STALL_LIMIT - 1)) stall_seen <= 1'b1;
    end
  end
`endif

endmodule
